// File: rtl/softmax_prob_streamer_pkg.sv
`default_nettype none
// softmax_prob_streamer_pkg: FSM encoding, quantiser width and log2 helper
// Rev 1.0
package softmax_prob_streamer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Extra bit on top of the probability width so the rounding add cannot wrap
  localparam int QUANT_GUARD_BITS = 1;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/softmax_out_fifo.sv
`default_nettype none
// softmax_out_fifo: synchronous FIFO of {last, data} with occupancy count
// Rev 1.0
module softmax_out_fifo
  import softmax_prob_streamer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     push_last,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic                     head_last,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = clog2_min1(DEPTH);

  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count_q;

  // Storage carries no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head_data = mem[rd_ptr][DATA_W-1:0];
  assign head_last = mem[rd_ptr][DATA_W];
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/softmax_prob_streamer.sv
`default_nettype none
// softmax_prob_streamer: reads a finished softmax row, quantises and streams it
// Rev 1.0
module softmax_prob_streamer
  import softmax_prob_streamer_pkg::*;
#(
  parameter int LARGE_SIZE = 16,
  parameter int ROW_WIDTH  = 64,
  parameter int OUT_SIZE   = 8,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          row_done,
  output logic [$clog2(ROW_WIDTH)-1:0]  read_addr,
  input  logic [LARGE_SIZE:0]           prob_buffer_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_SIZE-1:0]           out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  localparam int RAW = $clog2(ROW_WIDTH);
  localparam int CW  = $clog2(FIFO_DEPTH);
  localparam int QW  = LARGE_SIZE + 1 + QUANT_GUARD_BITS;
  localparam logic [RAW-1:0] LAST_IDX = RAW'(ROW_WIDTH - 1);
  localparam logic [QW-1:0]  RND      = QW'(1) << (SHIFT - 1);

  logic [1:0]          state_q;
  logic                row_done_q;
  logic [RAW-1:0]      issue_cnt;
  logic [RAW-1:0]      read_addr_q;
  logic                inflight_q;
  logic                inflight_last_q;
  logic                done_q;
  logic                overrun_q;

  logic [OUT_SIZE-1:0] head_data;
  logic                head_last;
  logic                fifo_empty;
  logic [CW:0]         fifo_count;

  logic                start;
  logic                pop;
  logic                credit;
  logic                issue;
  logic                issue_last;
  logic [QW-1:0]       q_sum;
  logic [QW-1:0]       q_val;
  logic [OUT_SIZE-1:0] q_data;

  assign start = row_done & ~row_done_q;
  assign pop   = out_valid & out_ready;

  // A pop this cycle frees a slot that the new read may claim
  assign credit = ((CW+2)'(fifo_count) + (CW+2)'(inflight_q)) <
                  ((CW+2)'(FIFO_DEPTH) + (CW+2)'(pop));
  assign issue      = (state_q == ST_READ) && credit;
  assign issue_last = issue && (issue_cnt == LAST_IDX);

  assign q_sum  = QW'(prob_buffer_out) + RND;
  assign q_val  = q_sum >> SHIFT;
  assign q_data = (|q_val[QW-1:OUT_SIZE]) ? '1 : q_val[OUT_SIZE-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      row_done_q      <= 1'b0;
      issue_cnt       <= '0;
      read_addr_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      row_done_q      <= row_done;
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      if (start && (state_q != ST_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            issue_cnt   <= '0;
            read_addr_q <= '0;
            state_q     <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue) begin
            issue_cnt <= issue_cnt + RAW'(1);
            if (issue_last) state_q <= ST_DRAIN;
            else            read_addr_q <= issue_cnt + RAW'(1);
          end
        end
        ST_DRAIN: begin
          // Last element leaving means FIFO and read pipe are both empty
          if (pop && head_last) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  softmax_out_fifo #(
    .DATA_W (OUT_SIZE),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (q_data),
    .push_last (inflight_last_q),
    .pop       (pop),
    .head_data (head_data),
    .head_last (head_last),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign read_addr = read_addr_q;
  assign out_valid = ~fifo_empty;
  assign out_data  = out_valid ? head_data : '0;
  assign out_last  = out_valid & head_last;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_softmax_prob_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// tb_softmax_prob_streamer: table-driven rows with a scoreboard on the output stream
// Rev 1.0
module tb_softmax_prob_streamer;

  localparam int LS = 16;
  localparam int RW = 4;
  localparam int OS = 8;
  localparam int SH = 8;
  localparam int FD = 2;

  logic          clk;
  logic          rst_n;
  logic          row_done;
  logic [1:0]    read_addr;
  logic [LS:0]   prob_buffer_out;
  logic          out_valid;
  logic          out_ready;
  logic [OS-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          overrun;

  softmax_prob_streamer #(
    .LARGE_SIZE (LS),
    .ROW_WIDTH  (RW),
    .OUT_SIZE   (OS),
    .SHIFT      (SH),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .row_done        (row_done),
    .read_addr       (read_addr),
    .prob_buffer_out (prob_buffer_out),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .busy            (busy),
    .done            (done),
    .overrun         (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered probability buffer: one-cycle read latency
  logic [LS:0] mem [RW];
  always @(posedge clk) prob_buffer_out <= mem[read_addr];

  typedef struct {
    logic [LS:0]   prob;
    logic [OS-1:0] exp_data;
    logic          exp_last;
  } vec_t;

  vec_t          vec [2*RW];
  logic [OS:0]   sb [$];
  int            checks;
  int            errors;
  int            done_cnt;
  int            acc_row;
  logic          prev_stall;
  logic [OS-1:0] prev_data;
  logic          found;
  logic          pat [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_row(input int r);
    for (int i = 0; i < RW; i++) begin
      mem[i] = vec[r*RW+i].prob;
      sb.push_back({vec[r*RW+i].exp_last, vec[r*RW+i].exp_data});
    end
  endtask

  task automatic start_edge();
    @(posedge clk); #1 row_done = 1'b1;
    @(posedge clk); #1 row_done = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(name, done_cnt != d0, 1);
  endtask

  // Output monitor: scoreboard compare, stall stability, read-ahead bound
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_row    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
      if (busy) chk("read_ahead", int'(read_addr) <= acc_row + 2, 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", {out_last, out_data}, 32'hFFFF_FFFF);
        else                chk("out_elem", {out_last, out_data}, sb.pop_front());
        acc_row++;
      end
      if (done) begin
        done_cnt++;
        acc_row = 0;
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{17'h01234, 8'h12, 1'b0};
    vec[1] = '{17'h0007F, 8'h00, 1'b0};
    vec[2] = '{17'h00080, 8'h01, 1'b0};
    vec[3] = '{17'h1FFFF, 8'hFF, 1'b1};
    vec[4] = '{17'h00000, 8'h00, 1'b0};
    vec[5] = '{17'h000FF, 8'h01, 1'b0};
    vec[6] = '{17'h0FF7F, 8'hFF, 1'b0};
    vec[7] = '{17'h0FF80, 8'hFF, 1'b1};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    checks = 0; errors = 0; done_cnt = 0; acc_row = 0;
    prev_stall = 1'b0; prev_data = '0;
    rst_n = 1'b0; row_done = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < RW; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1 chk("reset_vals", {read_addr, out_valid, out_data, out_last, busy, done, overrun}, 0);
    rst_n = 1'b1;

    // Row at full rate: latency 2, four back-to-back elements, done one cycle later
    out_ready = 1'b1;
    load_row(0);
    start_edge();
    @(negedge clk) chk("t1_lat0", {busy, out_valid}, 2'b10);
    @(negedge clk) chk("t1_lat1", out_valid, 0);
    for (int k = 0; k < RW; k++) begin
      @(negedge clk) chk("t1_stream", {out_valid, out_last}, {1'b1, k == RW-1});
    end
    @(negedge clk) chk("t1_done", {done, out_valid, busy}, 3'b100);
    chk("t1_sb_empty", sb.size(), 0);

    // Toggling backpressure
    load_row(1);
    start_edge();
    begin
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < 200) begin
        @(posedge clk); #1 out_ready = pat[n % 6];
        n++;
      end
      chk("t2_done_seen", done_cnt != d0, 1);
    end
    chk("t2_sb_empty", sb.size(), 0);

    // Long stall: two reads issued, FIFO full, then in-order drain
    out_ready = 1'b0;
    load_row(0);
    start_edge();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t3_addr", read_addr, 2);
    chk("t3_head", {out_valid, out_data}, {1'b1, 8'h12});
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done(50, "t3_done_seen");
    chk("t3_sb_empty", sb.size(), 0);

    // Second edge mid-row: sticky overrun, no extra row
    load_row(1);
    start_edge();
    start_edge();
    wait_done(50, "t4_done_seen");
    chk("t4_overrun", overrun, 1);
    repeat (10) @(posedge clk);
    @(negedge clk) chk("t4_idle", {busy, out_valid, overrun}, 3'b001);
    chk("t4_sb_empty", sb.size(), 0);

    // Asynchronous reset mid-READ
    load_row(0);
    start_edge();
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("t5_async", {read_addr, out_valid, out_data, out_last, busy, done, overrun}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    load_row(1);
    start_edge();
    wait_done(50, "t5_done_seen");
    chk("t5_sb_empty", sb.size(), 0);

    // row_done dropped and re-raised around done: seamless second row
    load_row(0);
    @(posedge clk); #1 row_done = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (out_valid && out_last) found = 1'b1;
    end
    chk("t6_last_seen", found, 1);
    row_done = 1'b0;
    @(posedge clk); #1;
    load_row(1);
    row_done = 1'b1;
    @(negedge clk) chk("t6_done", {done, busy}, 2'b10);
    @(negedge clk) chk("t6_restart", busy, 1);
    wait_done(50, "t6_done_seen");
    chk("t6_overrun", overrun, 0);
    chk("t6_sb_empty", sb.size(), 0);
    row_done = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
